imm_extend_unit: RTL and testbench



---
 rtl/dp_pkg.sv | 8 +
 rtl/imm_extend_core.sv | 20 ++
 rtl/imm_extend_unit.sv | 84 ++++++++
 tb/tb_imm_extend_unit.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/dp_pkg.sv
// dp_pkg: shared datapath constants for immediate extension modes and skid occupancy
package dp_pkg;
  localparam logic [1:0] EXT_ZERO      = 2'd0;
  localparam logic [1:0] EXT_SIGN      = 2'd1;
  localparam logic [1:0] EXT_SIGN_SHL1 = 2'd2;
  localparam logic [1:0] EXT_UPPER     = 2'd3;
  typedef enum logic [1:0] {OCC_EMPTY, OCC_ONE, OCC_FULL} occ_e;
endpackage

// File: rtl/imm_extend_core.sv
// imm_extend_core: combinational immediate extension mode mux
module imm_extend_core
  import dp_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int OUT_W = 16
) (
  input  logic [IN_W-1:0]  ext_in,
  input  logic [1:0]       mode,
  output logic [OUT_W-1:0] ext_out
);
  logic [OUT_W-1:0] zx, sx, up;
  assign zx = {{(OUT_W-IN_W){1'b0}}, ext_in};
  assign sx = {{(OUT_W-IN_W){ext_in[IN_W-1]}}, ext_in};
  assign up = {ext_in, {(OUT_W-IN_W){1'b0}}};
  always_comb
    ext_out = mode == EXT_ZERO      ? zx :
              mode == EXT_SIGN      ? sx :
              mode == EXT_SIGN_SHL1 ? {sx[OUT_W-2:0], 1'b0} : up;
endmodule

// File: rtl/imm_extend_unit.sv
// imm_extend_unit: pipelined immediate extender with valid/ready and a 2-entry skid buffer
module imm_extend_unit
  import dp_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  ext_in,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] extend_out,
  output logic [1:0]       out_mode
);
  if (IN_W < 2 || IN_W > 32) begin : g_bad_in_w
    $error("imm_extend_unit: IN_W must be in 2..32");
  end
  if (OUT_W < IN_W + 1) begin : g_bad_out_w
    $error("imm_extend_unit: OUT_W must be at least IN_W+1");
  end
  occ_e             state_q, state_d;
  logic [OUT_W-1:0] ext_val, main_q, main_d, skid_q, skid_d;
  logic [1:0]       main_m_q, main_m_d, skid_m_q, skid_m_d;
  logic             accept, drain;
  imm_extend_core #(.IN_W(IN_W), .OUT_W(OUT_W)) u_core (
    .ext_in (ext_in),
    .mode   (mode),
    .ext_out(ext_val)
  );
  assign in_ready   = state_q != OCC_FULL;
  assign out_valid  = state_q != OCC_EMPTY;
  assign extend_out = main_q;
  assign out_mode   = main_m_q;
  assign accept     = in_valid & in_ready;
  assign drain      = out_valid & out_ready;
  always_comb begin
    state_d  = state_q;
    main_d   = main_q;
    main_m_d = main_m_q;
    skid_d   = skid_q;
    skid_m_d = skid_m_q;
    unique case (state_q)
      OCC_EMPTY: if (accept) begin
        main_d   = ext_val;
        main_m_d = mode;
        state_d  = OCC_ONE;
      end
      OCC_ONE: if (accept && !drain) begin
        skid_d   = ext_val;
        skid_m_d = mode;
        state_d  = OCC_FULL;
      end else if (accept) begin
        main_d   = ext_val;
        main_m_d = mode;
      end else if (drain) begin
        state_d  = OCC_EMPTY;
      end
      OCC_FULL: if (drain) begin
        main_d   = skid_q;
        main_m_d = skid_m_q;
        state_d  = OCC_ONE;
      end
      default: state_d = OCC_EMPTY;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q  <= OCC_EMPTY;
      main_q   <= '0;
      main_m_q <= '0;
      skid_q   <= '0;
      skid_m_q <= '0;
    end else begin
      state_q  <= state_d;
      main_q   <= main_d;
      main_m_q <= main_m_d;
      skid_q   <= skid_d;
      skid_m_q <= skid_m_d;
    end
endmodule

// File: tb/tb_imm_extend_unit.sv
// tb_imm_extend_unit: randomized and directed checks against a queue-based reference model
module tb_imm_extend_unit;
  import dp_pkg::*;
  logic        clk = 0, rst_n = 0;
  logic        in_valid = 0, out_ready = 0;
  logic [7:0]  ext_in = 0;
  logic [1:0]  mode = 0;
  logic        in_ready, out_valid;
  logic [15:0] extend_out;
  logic [1:0]  out_mode;
  logic        w_in_valid = 0, w_in_ready, w_out_valid;
  logic [11:0] w_ext_in = 0;
  logic [1:0]  w_mode = 0, w_out_mode;
  logic [31:0] w_extend_out;
  int n_pass = 0, n_tot = 0;
  typedef struct { longint d; logic [1:0] m; } item_t;
  item_t q[$];

  imm_extend_unit dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ext_in(ext_in), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
    .extend_out(extend_out), .out_mode(out_mode)
  );
  imm_extend_unit #(.IN_W(12), .OUT_W(32)) u_wide (
    .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .ext_in(w_ext_in), .mode(w_mode), .out_valid(w_out_valid), .out_ready(1'b1),
    .extend_out(w_extend_out), .out_mode(w_out_mode)
  );

  always #5 clk = ~clk;

  function automatic longint ext_model(longint x, int m, int iw, int ow);
    longint half = longint'(1) << (iw - 1);
    longint v    = x >= half ? x - 2 * half : x;
    longint mask = (longint'(1) << ow) - 1;
    return m == 0 ? x : m == 1 ? v & mask : m == 2 ? (v * 2) & mask : (x << (ow - iw)) & mask;
  endfunction

  task automatic check(input string name, input longint got, input longint exp);
    n_tot++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  always @(negedge rst_n) q.delete();

  always @(negedge clk) if (rst_n) begin
    check("in_ready_occ", in_ready, q.size() < 2);
    check("out_valid_occ", out_valid, q.size() > 0);
    if (out_valid && q.size() > 0) begin
      check("out_data", extend_out, q[0].d);
      check("out_mode", out_mode, q[0].m);
    end
    if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
    if (in_valid && in_ready) q.push_back('{ext_model(ext_in, mode, 8, 16), mode});
  end

  task automatic send(input logic [7:0] x, input logic [1:0] m);
    bit acc = 0;
    int n = 0;
    in_valid = 1; ext_in = x; mode = m;
    while (!acc && n < 50) begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1; n++;
    end
    if (!acc) check("send_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    in_valid = 0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  typedef struct { logic [7:0] x; logic [1:0] m; logic [15:0] e; } vec_t;
  vec_t vecs[7] = '{
    '{8'h80, EXT_ZERO, 16'h0080}, '{8'h80, EXT_SIGN, 16'hFF80},
    '{8'h80, EXT_SIGN_SHL1, 16'hFF00}, '{8'h80, EXT_UPPER, 16'h8000},
    '{8'h7F, EXT_SIGN, 16'h007F}, '{8'h7F, EXT_SIGN_SHL1, 16'h00FE},
    '{8'hFF, EXT_SIGN_SHL1, 16'hFFFE}};

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_extend_out", extend_out, 0);
    check("rst_out_mode", out_mode, 0);
    rst_n = 1;
    out_ready = 1;
    idle(1);
    foreach (vecs[i]) begin
      check("model_literal", ext_model(vecs[i].x, vecs[i].m, 8, 16), vecs[i].e);
      send(vecs[i].x, vecs[i].m);
      in_valid = 0;
      check("mode_valid", out_valid, 1);
      check("mode_data", extend_out, vecs[i].e);
      check("mode_tag", out_mode, vecs[i].m);
    end
    idle(2);
    out_ready = 0;
    send(8'h01, EXT_SIGN);
    send(8'h02, EXT_SIGN);
    check("bp_in_ready_low", in_ready, 0);
    check("bp_head", extend_out, 16'h0001);
    in_valid = 1; ext_in = 8'h03;
    repeat (3) begin @(posedge clk); #1; end
    check("bp_still_full", in_ready, 0);
    check("bp_head_stable", extend_out, 16'h0001);
    out_ready = 1;
    send(8'h03, EXT_SIGN);
    idle(4);
    for (int i = 0; i < 16; i++) send(8'(i * 7 + 3), 2'($urandom));
    idle(3);
    out_ready = 0;
    send(8'h11, EXT_ZERO);
    send(8'h22, EXT_ZERO);
    in_valid = 0;
    check("full_before_reset", in_ready, 0);
    #1 rst_n = 0;
    #1;
    check("async_out_valid", out_valid, 0);
    check("async_extend_out", extend_out, 0);
    check("async_in_ready", in_ready, 1);
    #1 rst_n = 1;
    @(posedge clk); #1;
    out_ready = 1;
    send(8'h33, EXT_ZERO);
    in_valid = 0;
    check("post_reset_data", extend_out, 16'h0033);
    idle(3);
    check("wide_model_sign", ext_model(12'h800, 1, 12, 32), 32'hFFFFF800);
    check("wide_model_upper", ext_model(12'h800, 3, 12, 32), 32'h80000000);
    w_in_valid = 1; w_ext_in = 12'h800; w_mode = EXT_SIGN;
    @(posedge clk); #1;
    check("wide_valid", w_out_valid, 1);
    check("wide_sign", w_extend_out, 32'hFFFFF800);
    w_mode = EXT_UPPER;
    @(posedge clk); #1;
    w_in_valid = 0;
    check("wide_upper", w_extend_out, 32'h80000000);
    check("wide_mode", w_out_mode, EXT_UPPER);
    for (int ph = 0; ph < 3; ph++)
      repeat (800) begin
        in_valid  = $urandom_range(0, 1) == 1;
        ext_in    = 8'($urandom);
        mode      = 2'($urandom);
        out_ready = $urandom_range(0, 3) < 3 - ph;
        @(posedge clk); #1;
      end
    out_ready = 1;
    idle(4);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
